// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// UART receive stage: a 16x-oversampled serial receiver feeding a
// first-word-fall-through byte FIFO, with sticky framing, overrun and
// (optionally) parity error flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined     -> 8E1 frames, even parity checked over data + parity bit
//   not defined -> 8N1 frames, parity_err_o tied low
//
// Parameters
//   FIFO_DEPTH  receive FIFO entries (power of two, 2..256)
//   DIV_W       width of the baud divisor
//
// Ports
//   clk_i         system clock
//   reset_i       asynchronous active-high reset
//   baud_div_i    clock cycles per oversample tick, minus one
//   rx_i          asynchronous serial line, idle high
//   rd_en_i       pop the FIFO head (ignored while empty)
//   clear_i       clear all sticky error flags
//   rd_data_o     FIFO head byte, 0x00 while empty
//   rd_valid_o    FIFO not empty
//   fifo_count_o  FIFO occupancy
//   frame_err_o   sticky: stop bit sampled low
//   overrun_o     sticky: byte dropped because the FIFO was full
//   parity_err_o  sticky: parity mismatch

module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic                          rx_i,
  input  logic                          rd_en_i,
  input  logic                          clear_i,
  output logic [7:0]                    rd_data_o,
  output logic                          rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          parity_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       scnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;
  logic             stop_sample;
  logic             par_bad;
  logic             push_req;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Two-flop synchronizer plus one extra stage so IDLE can require a high
  // sample before accepting a falling edge as a start bit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Oversample tick generator. Held at zero in IDLE so the tick phase lines
  // up with the start edge. The >= compare keeps the counter from running
  // away if the divisor is lowered mid-count.
  assign tick = (div_cnt >= baud_div_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt <= '0;
    end else if (state == IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign bit_end     = tick && (scnt == 4'd15);
  assign stop_sample = (state == STOP) && bit_end;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Even parity: data bits plus the parity bit must XOR to zero.
  assign par_bad = ^{shreg, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  assign push_req = stop_sample && rx_s && !par_bad;

  // Receive FSM. scnt wraps 15 -> 0 on its own, so each bit state only
  // needs to act on the 16th tick.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      scnt    <= 4'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            scnt  <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (scnt == 4'd7) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                scnt    <= 4'd0;
                bit_idx <= 3'd0;
              end
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'd15) begin
              shreg   <= {rx_s, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (bit_idx == 3'd7) state <= PARITY;
`else
              if (bit_idx == 3'd7) state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'd15) begin
              par_bit <= rx_s;
              state   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'd15) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO control. A pop frees the slot a simultaneous push needs, so a
  // full FIFO accepts a push in the same cycle as a pop.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd_en_i && !empty;
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; the head byte is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign rd_data_o    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign rd_valid_o   = !empty;
  assign fifo_count_o = wr_ptr - rd_ptr;

  // Sticky flags: a set in the same cycle as clear_i wins.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (stop_sample && !rx_s) frame_err_o <= 1'b1;
      else if (clear_i)         frame_err_o <= 1'b0;

      if (push_req && full && !do_pop) overrun_o <= 1'b1;
      else if (clear_i)                overrun_o <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      parity_err_o <= 1'b0;
    end else if (stop_sample && rx_s && par_bad) begin
      parity_err_o <= 1'b1;
    end else if (clear_i) begin
      parity_err_o <= 1'b0;
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. Frames are built bit by bit from the
// line protocol and a queue-based model tracks the expected FIFO contents
// and sticky flags. Define UART_RX_PARITY_EN to exercise the 8E1 build.

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS  = PAR_EN ? 11 : 10;
  // Half a start bit, then 16 ticks for every following bit.
  localparam int FRAME_TICKS = 8 + 16 * (FRAME_BITS - 1);

  logic                     clk_i;
  logic                     reset_i;
  logic [DIV_W-1:0]         baud_div_i;
  logic                     rx_i;
  logic                     rd_en_i;
  logic                     clear_i;
  logic [7:0]               rd_data_o;
  logic                     rd_valid_o;
  logic [$clog2(DEPTH):0]   fifo_count_o;
  logic                     frame_err_o;
  logic                     overrun_o;
  logic                     parity_err_o;

  logic [7:0] exp_q[$];
  logic       m_frame;
  logic       m_overrun;
  logic       m_parity;

  int vector_count = 0;
  int miscompare_count = 0;
  int first_valid_cycle;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .baud_div_i   (baud_div_i),
    .rx_i         (rx_i),
    .rd_en_i      (rd_en_i),
    .clear_i      (clear_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .fifo_count_o (fifo_count_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the sequence ended");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vector_count++;
    assert (obs === exp) else begin
      miscompare_count++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model.
  task automatic checkState(input string tag);
    checkOutput({tag, "_count"},  32'(fifo_count_o), 32'(exp_q.size()));
    checkOutput({tag, "_valid"},  32'(rd_valid_o),   32'(exp_q.size() != 0));
    checkOutput({tag, "_frame"},  32'(frame_err_o),  32'(m_frame));
    checkOutput({tag, "_ovr"},    32'(overrun_o),    32'(m_overrun));
    checkOutput({tag, "_parity"}, 32'(parity_err_o), 32'(m_parity));
    if (exp_q.size() != 0) checkOutput({tag, "_data"}, 32'(rd_data_o), 32'(exp_q[0]));
  endtask

  // Drive one complete frame on rx_i. Optionally raise rd_en_i for the single
  // cycle whose rising edge is the stop-bit sample: 3 cycles from line low to
  // START, then FRAME_TICKS ticks of (div+1) cycles each.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic par_flip, input logic pop_at_stop,
                               input int div);
    logic [10:0] bits;
    logic [3:0]  idx;
    logic        was_valid;
    int          bit_cycles;
    int          total;
    int          pop_cycle;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (PAR_EN) begin
      bits[9]  = (^data) ^ par_flip;
      bits[10] = stop_bit;
    end else begin
      bits[9]  = stop_bit;
    end
    baud_div_i = DIV_W'(div);
    bit_cycles = 16 * (div + 1);
    total      = FRAME_BITS * bit_cycles;
    pop_cycle  = 2 + FRAME_TICKS * (div + 1);
    was_valid  = rd_valid_o;
    first_valid_cycle = -1;
    for (int c = 0; c < total; c++) begin
      if (!was_valid && rd_valid_o && first_valid_cycle < 0) first_valid_cycle = c;
      idx     = 4'(c / bit_cycles);
      rx_i    = bits[idx];
      rd_en_i = pop_at_stop && (c == pop_cycle);
      @(negedge clk_i);
    end
    rx_i    = 1'b1;
    rd_en_i = 1'b0;
    // Model: a requested pop happens whenever data is present; a good frame
    // is stored if there is room after that pop, else it is an overrun.
    if (pop_at_stop && exp_q.size() != 0) void'(exp_q.pop_front());
    if (!stop_bit) begin
      m_frame = 1'b1;
    end else if (PAR_EN && par_flip) begin
      m_parity = 1'b1;
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(data);
    end else begin
      m_overrun = 1'b1;
    end
    repeat (4) @(negedge clk_i);
  endtask

  task automatic popOne(input string tag);
    checkOutput({tag, "_valid"}, 32'(rd_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      checkOutput({tag, "_data"}, 32'(rd_data_o), 32'(exp_q[0]));
      rd_en_i = 1'b1;
      @(negedge clk_i);
      rd_en_i = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic clearFlags();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    m_frame   = 1'b0;
    m_overrun = 1'b0;
    m_parity  = 1'b0;
  endtask

  initial begin
    int         r_div;
    int         r_pops;
    logic [7:0] r_data;
    logic       r_stop;
    logic       r_flip;
    logic [7:0] abort_data;
    logic [2:0] bi;

    reset_i    = 1'b1;
    rx_i       = 1'b1;
    rd_en_i    = 1'b0;
    clear_i    = 1'b0;
    baud_div_i = '0;
    m_frame    = 1'b0;
    m_overrun  = 1'b0;
    m_parity   = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk_i);
    checkOutput("rst_valid",  32'(rd_valid_o),   32'd0);
    checkOutput("rst_data",   32'(rd_data_o),    32'h00);
    checkOutput("rst_count",  32'(fifo_count_o), 32'd0);
    checkOutput("rst_frame",  32'(frame_err_o),  32'd0);
    checkOutput("rst_ovr",    32'(overrun_o),    32'd0);
    checkOutput("rst_parity", 32'(parity_err_o), 32'd0);
    reset_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkState("idle");

    // Clean byte at one tick per cycle, with push latency bound.
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    vector_count++;
    assert (first_valid_cycle >= 0 && first_valid_cycle <= 157 + (PAR_EN ? 16 : 0)) else begin
      miscompare_count++;
      $error("[TB] FAIL clean_latency: observed=%0d cycles expected<=%0d",
             first_valid_cycle, 157 + (PAR_EN ? 16 : 0));
    end
    checkOutput("clean_byte", 32'(rd_data_o), 32'hA5);
    checkState("clean");
    popOne("clean_pop");
    checkState("clean_empty");

    // Overrun: 17 bytes into a 16-entry FIFO, then drain back-to-back.
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, 0);
    checkOutput("ovr_count_full", 32'(fifo_count_o), 32'd16);
    checkOutput("ovr_flag",       32'(overrun_o),    32'd1);
    checkState("ovr");
    while (exp_q.size() != 0) popOne("ovr_drain");
    checkState("ovr_empty");
    clearFlags();
    checkState("ovr_clr");

    // False start: a 4-cycle glitch must not produce a byte or a flag.
    baud_div_i = '0;
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (40) @(negedge clk_i);
    checkState("false_start");
    applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0, 0);
    checkState("after_false");
    popOne("after_false_pop");

    // Framing error, clear, then a good copy of the same byte.
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("frame_flag", 32'(frame_err_o), 32'd1);
    checkState("frame_err");
    clearFlags();
    checkState("frame_clr");
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 0);
    checkState("frame_next");
    popOne("frame_pop");

    // Push and pop colliding on a full FIFO.
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 0);
    checkState("coll_full");
    applyStimulus(8'h77, 1'b1, 1'b0, 1'b1, 0);
    checkOutput("coll_count", 32'(fifo_count_o), 32'd16);
    checkOutput("coll_ovr",   32'(overrun_o),    32'd0);
    checkState("coll");
    while (exp_q.size() != 0) popOne("coll_drain");
    checkState("coll_empty");

    // Randomized frames, divisors, stop bits and reads.
    for (int n = 0; n < 20; n++) begin
      r_div  = $urandom_range(0, 2);
      r_data = 8'($urandom);
      r_stop = ($urandom_range(0, 9) != 0);
      r_flip = PAR_EN && ($urandom_range(0, 7) == 0);
      applyStimulus(r_data, r_stop, r_flip, 1'b0, r_div);
      checkState("rand");
      r_pops = $urandom_range(0, 2);
      for (int k = 0; k < r_pops; k++) popOne("rand_pop");
      if ($urandom_range(0, 4) == 0) begin
        clearFlags();
        checkState("rand_clr");
      end
    end

    // Reset during data bit 4 with a byte buffered and a flag set.
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 0);
    checkState("pre_abort");
    baud_div_i = '0;
    abort_data = 8'h5A;
    for (int c = 0; c < 16 * 5 + 8; c++) begin
      if (c < 16) begin
        rx_i = 1'b0;
      end else begin
        bi   = 3'((c - 16) / 16);
        rx_i = abort_data[bi];
      end
      @(negedge clk_i);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    exp_q.delete();
    m_frame   = 1'b0;
    m_overrun = 1'b0;
    m_parity  = 1'b0;
    checkOutput("abort_valid",  32'(rd_valid_o),   32'd0);
    checkOutput("abort_data",   32'(rd_data_o),    32'h00);
    checkOutput("abort_count",  32'(fifo_count_o), 32'd0);
    checkOutput("abort_frame",  32'(frame_err_o),  32'd0);
    checkOutput("abort_ovr",    32'(overrun_o),    32'd0);
    checkOutput("abort_parity", 32'(parity_err_o), 32'd0);
    rx_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    repeat (20) @(negedge clk_i);
    checkState("post_abort");
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("post_abort_byte", 32'(rd_data_o), 32'h5A);
    checkState("post_abort_rx");
    popOne("post_abort_pop");

`ifdef UART_RX_PARITY_EN
    // 0x5A has even weight, so a parity bit of 1 is a mismatch.
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("par_flag",  32'(parity_err_o), 32'd1);
    checkOutput("par_count", 32'(fifo_count_o), 32'd0);
    checkState("par_err");
    clearFlags();
    checkState("par_clr");
`endif

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
